// File: rtl/regdbg_pkg.sv
// Shared definitions for the register-file debug access port:
// register file geometry defaults and the controller state encoding.
package regdbg_pkg;

  localparam int REG_AW = 5;
  localparam int REG_DW = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DUMP_RD = 3'd1,
    ST_DUMP_TX = 3'd2,
    ST_LOAD    = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/regdbg_port.sv
// Debug access initiator for the register file. Streams every register out
// over a valid/ready channel (dump), or loads r1..r(2**AW-1) in order from a
// valid/ready input channel (load). Used only while the CPU is held; the
// integration level muxes rn/wn/d/we against the datapath using busy.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | waiting for start_dump / start_load
// ST_DUMP_RD | rn=idx, capture q into the output buffer
// ST_DUMP_TX | hold out_valid/out_idx/out_data until out_ready
// ST_LOAD    | in_ready=1, each accepted word becomes a one-cycle write
// ST_DONE    | one-cycle done pulse, then back to idle
module regdbg_port
  import regdbg_pkg::*;
#(
  parameter int AW = REG_AW,
  parameter int DW = REG_DW
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          start_dump,
  input  logic          start_load,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] rn,
  input  logic [DW-1:0] q,
  output logic [AW-1:0] wn,
  output logic [DW-1:0] d,
  output logic          we,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_idx,
  output logic [DW-1:0] out_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data
);

  localparam logic [AW-1:0] IDX_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] IDX_LAST = '1;

  state_t        state;
  logic [AW-1:0] idx;

  // Status and handshake outputs decoded straight from the state register.
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);
  assign in_ready = (state == ST_LOAD);
  assign rn       = idx;

  // Sequencer: walks idx through the register file and owns the output
  // buffer (out_*) and the write-port registers (wn/d/we).
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state     <= ST_IDLE;
      idx       <= '0;
      wn        <= '0;
      d         <= '0;
      we        <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
    end else begin
      // we is a single-cycle pulse; only an accepted load word raises it.
      we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_dump) begin
            state <= ST_DUMP_RD;
            idx   <= '0;
          end else if (start_load) begin
            // r0 is hardwired to zero, so loading starts at r1.
            state <= ST_LOAD;
            idx   <= IDX_ONE;
          end
        end

        ST_DUMP_RD: begin
          if (abort) begin
            state <= ST_IDLE;
            idx   <= '0;
          end else begin
            out_data  <= q;
            out_idx   <= idx;
            out_valid <= 1'b1;
            state     <= ST_DUMP_TX;
          end
        end

        ST_DUMP_TX: begin
          if (abort) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
            idx       <= '0;
          end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            if (idx == IDX_LAST) begin
              state <= ST_DONE;
            end else begin
              idx   <= idx + IDX_ONE;
              state <= ST_DUMP_RD;
            end
          end
        end

        ST_LOAD: begin
          // abort beats a same-cycle handshake: the word is dropped.
          if (abort) begin
            state <= ST_IDLE;
            idx   <= '0;
          end else if (in_valid) begin
            wn <= idx;
            d  <= in_data;
            we <= 1'b1;
            if (idx == IDX_LAST) begin
              state <= ST_DONE;
            end else begin
              idx <= idx + IDX_ONE;
            end
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
          idx   <= '0;
        end

        default: begin
          state <= ST_IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

endmodule
